red_seq_ctrl: RTL and testbench
===============================

// Module: red_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RED (byte-reduction) operation using one shared 10-bit adder.
//  Replaces the five parallel 4-bit CLA slices of the combinational reducer.
//  Sits in the ALU execute stage behind a valid/ready handshake; EX stalls while busy=1.
//  Result = sext16( sext(a[15:8]) + sext(a[7:0]) + sext(b[15:8]) + sext(b[7:0]) ), all bytes signed.
// PARAMETERS
//  BYTE_W   8   operand byte width; only 8 is supported (elaboration $error otherwise)
//  SUM_W    10  internal accumulator width: 4 signed bytes -> range -512..+508
//  OUT_W    16  result width; SUM_W result sign-extended to OUT_W
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands a/b valid
//  in_ready   out  1      block can accept operands (1 only in IDLE)
//  a          in   16     first operand word
//  b          in   16     second operand word
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      consumer accepts result
//  result     out  16     reduction result, sign-extended
//  busy       out  1      1 in any state except IDLE
//  flush      in   1      (RED_FLUSH_EN only) abort current operation
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, result=16'h0000, busy=0, op regs=0.
//  FSM states: IDLE -> SUM_A -> SUM_B -> SUM_F -> DONE -> IDLE.
//  IDLE: in_ready=1. in_valid&in_ready at edge k -> latch a,b; go SUM_A.
//  SUM_A (cycle k+1): acc_a <= sext10(a[7:0]) + sext10(a[15:8]); go SUM_B.
//  SUM_B (cycle k+2): acc_b <= sext10(b[7:0]) + sext10(b[15:8]); go SUM_F.
//  SUM_F (cycle k+3): result <= sext16(acc_a + acc_b); go DONE.
//  DONE: out_valid=1 visible after edge k+3 (latency 3 edges accept->valid).
//  DONE with out_ready=1 at edge -> IDLE, out_valid=0; result keeps its last value.
//  DONE with out_ready=0: stay; result and out_valid stable (no glitch, no recompute).
//  Min throughput: one op per 5 cycles. No accept in DONE, even if out_ready=1 the same cycle.
//  Shared adder: one 10-bit two's-complement add per cycle; carry out of bit 9 discarded.
//  Overflow is impossible in range: no saturation and no flag.
//  in_valid in non-IDLE states is ignored; a/b are not re-sampled.
//  Inputs a/b only need to be stable in the accept cycle.
//  Reset asserted mid-operation: immediate return to reset values; the op is lost.
// CONFIGURATION
//  RED_FLUSH_EN defined: adds input flush.
//   - flush=1 at an edge forces IDLE and clears out_valid and busy; result is unchanged.
//   - flush has priority over accept and over out_ready.
//   - flush in IDLE with in_valid=1: no accept.
//  RED_FLUSH_EN undefined: no flush port; the operation always runs to DONE.
// STRUCTURE
//  Package red_pkg:
//   - typedef enum logic [2:0] red_state_t {IDLE,SUM_A,SUM_B,SUM_F,DONE}
//   - localparams RED_BYTE_W=8, RED_SUM_W=10
//   - function sext_byte(8->10)
//  Sub-module red_add10: shared 10-bit adder, built from two CLA_adder_4 slices plus a 2-bit top
//   slice with carry chain; operand muxes are selected by state.
//  Controller: FSM, operand/accumulator registers and handshake logic in red_seq_ctrl.
// TESTING
//  1 a=16'h7F7F,b=16'h7F7F, out_ready=1 -> out_valid 3 edges after accept, result=16'h01FC.
//  2 a=16'h8080,b=16'h8080 -> result=16'hFE00 (-512); a=16'h0102,b=16'hFF01 -> 16'h0003.
//  3 Backpressure: out_ready=0 for 6 cycles after out_valid.
//     -> result and out_valid stable; in_ready=0; new in_valid is ignored.
//  4 in_valid held high back-to-back -> accepts spaced exactly 5 cycles; each result is correct.
//  5 rst_n=0 asserted in SUM_B -> outputs are reset values at once; next op after release is correct.
//  6 RED_FLUSH_EN: flush in SUM_A -> IDLE next edge, out_valid never rises.
//     flush in DONE -> out_valid drops.

Source files
------------

// File: rtl/red_pkg.sv
// Shared types and helpers for the RED byte-reduction sequencer.
// The optional RED_FLUSH_EN build adds an abort input to red_seq_ctrl.
package red_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SUM_A = 3'd1,
        SUM_B = 3'd2,
        SUM_F = 3'd3,
        DONE  = 3'd4
    } red_state_t;

    localparam int RED_BYTE_W = 8;
    localparam int RED_SUM_W  = 10;

    function automatic logic signed [RED_SUM_W-1:0] sext_byte(input logic signed [RED_BYTE_W-1:0] v);
        return {{(RED_SUM_W-RED_BYTE_W){v[RED_BYTE_W-1]}}, v};
    endfunction

endpackage

// File: rtl/CLA_adder_4.sv
// 4-bit carry-lookahead slice used as a building block of the shared RED adder.
module CLA_adder_4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = c_i;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign s_o = p ^ c[3:0];
    assign c_o = c[4];

endmodule

// File: rtl/red_add10.sv
// Shared 10-bit two's-complement adder of the RED sequencer; the sequencer state
// picks which operand pair is summed this cycle. Carry out of bit 9 is dropped.
module red_add10
    import red_pkg::*;
(
    input  red_state_t       state_i,
    input  logic [15:0]      a_i,
    input  logic [15:0]      b_i,
    input  logic [9:0]       acc_a_i,
    input  logic [9:0]       acc_b_i,
    output logic [9:0]       sum_o
);

    logic [9:0] x;
    logic [9:0] y;
    logic       c4;
    logic       c8;
    logic       c8_unused;

    always_comb begin
        x = acc_a_i;
        y = acc_b_i;
        case (state_i)
            SUM_A: begin
                x = sext_byte(a_i[7:0]);
                y = sext_byte(a_i[15:8]);
            end
            SUM_B: begin
                x = sext_byte(b_i[7:0]);
                y = sext_byte(b_i[15:8]);
            end
            default: ;
        endcase
    end

    CLA_adder_4 u_cla_lo (
        .a_i (x[3:0]),
        .b_i (y[3:0]),
        .c_i (1'b0),
        .s_o (sum_o[3:0]),
        .c_o (c4)
    );

    CLA_adder_4 u_cla_mid (
        .a_i (x[7:4]),
        .b_i (y[7:4]),
        .c_i (c4),
        .s_o (sum_o[7:4]),
        .c_o (c8)
    );

    // Top 2-bit slice: wrap-around is intended, the 4-byte sum always fits in 10 bits.
    assign {c8_unused, sum_o[9:8]} = {1'b0, x[9:8]} + {1'b0, y[9:8]} + {2'b00, c8};

endmodule

// File: rtl/red_seq_ctrl.sv
// Multi-cycle RED sequencer: sums four signed bytes of a/b through one shared adder.
// Define RED_FLUSH_EN to add the flush abort input.
module red_seq_ctrl
    import red_pkg::*;
#(
    parameter int BYTE_W = 8,
    parameter int SUM_W  = 10,
    parameter int OUT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*BYTE_W-1:0] a,
    input  logic [2*BYTE_W-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    result,
    output logic                busy
`ifdef RED_FLUSH_EN
    ,
    input  logic                flush
`endif
);

    generate
        if (BYTE_W != RED_BYTE_W || SUM_W != RED_SUM_W || OUT_W < SUM_W) begin : g_param_chk
            $error("red_seq_ctrl: only BYTE_W=8, SUM_W=10, OUT_W>=10 are supported");
        end
    endgenerate

    function automatic logic [OUT_W-1:0] sext_out(input logic signed [SUM_W-1:0] v);
        return OUT_W'(v);
    endfunction

    red_state_t              state_q;
    red_state_t              state_d;
    logic [2*BYTE_W-1:0]     a_q;
    logic [2*BYTE_W-1:0]     b_q;
    logic signed [SUM_W-1:0] acc_a_q;
    logic signed [SUM_W-1:0] acc_b_q;
    logic [OUT_W-1:0]        result_q;
    logic signed [SUM_W-1:0] sum;
    logic                    flush_w;
    logic                    accept;

`ifdef RED_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign accept    = in_valid & in_ready & ~flush_w;

    red_add10 u_add (
        .state_i (state_q),
        .a_i     (a_q),
        .b_i     (b_q),
        .acc_a_i (acc_a_q),
        .acc_b_i (acc_b_q),
        .sum_o   (sum)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SUM_A;
            SUM_A:   state_d = SUM_B;
            SUM_B:   state_d = SUM_F;
            SUM_F:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_w) begin
            state_d = IDLE;
        end
    end

    // One adder result is captured per compute state; flush suppresses every capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_a_q  <= '0;
            acc_b_q  <= '0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q <= a;
                b_q <= b;
            end
            if (state_q == SUM_A && !flush_w) begin
                acc_a_q <= sum;
            end
            if (state_q == SUM_B && !flush_w) begin
                acc_b_q <= sum;
            end
            if (state_q == SUM_F && !flush_w) begin
                result_q <= sext_out(sum);
            end
        end
    end

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Randomized self-checking bench for red_seq_ctrl against a plain-arithmetic reference.
module tb_red_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [15:0] result;
`ifdef RED_FLUSH_EN
    logic        flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    red_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef RED_FLUSH_EN
        ,
        .flush     (flush)
`endif
    );

    function automatic logic [15:0] ref_red(input logic [15:0] x, input logic [15:0] y);
        int s;
        s = int'($signed(x[15:8])) + int'($signed(x[7:0]))
          + int'($signed(y[15:8])) + int'($signed(y[7:0]));
        return s[15:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Starts and ends at a negedge with the DUT idle.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input int stall);
        logic [15:0] exp;
        int lat;
        exp = ref_red(ta, tb);
        check_eq("in_ready_idle", in_ready, 1);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, 3);
        check_eq("result", result, exp);
        check_eq("busy_done", busy, 1);
        check_eq("in_ready_done", in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'($urandom);
            a = 16'($urandom);
            b = 16'($urandom);
            @(negedge clk);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_result", result, exp);
            check_eq("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid = 1'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("valid_drop", out_valid, 0);
        check_eq("busy_idle", busy, 0);
        check_eq("result_kept", result, exp);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] last_res;
        int last_acc;

        repeat (2) @(negedge clk);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h7F7F, 16'h7F7F, 0);
        run_op(16'h8080, 16'h8080, 2);
        run_op(16'h0102, 16'hFF01, 6);

        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) @(negedge clk);
            run_op(16'($urandom), 16'($urandom), int'($urandom_range(6, 0)));
        end

        // Back-to-back: in_valid held high, consumer always ready.
        last_acc = -1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            if (in_ready) begin
                if (last_acc >= 0) check_eq("b2b_spacing", c - last_acc, 5);
                last_acc = c;
                a = 16'($urandom);
                b = 16'($urandom);
                q.push_back(ref_red(a, b));
            end
            if (out_valid) begin
                check_eq("b2b_pending", q.size() > 0, 1);
                if (q.size() > 0) check_eq("b2b_result", result, q.pop_front());
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid && q.size() > 0) check_eq("b2b_result", result, q.pop_front());
            @(negedge clk);
        end
        check_eq("b2b_drained", q.size(), 0);

        // Reset while in SUM_B.
        a = 16'h1234;
        b = 16'h5678;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_result", result, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'($urandom), 16'($urandom), 1);

`ifdef RED_FLUSH_EN
        last_res = result;
        a = 16'h7F7F;
        b = 16'h0101;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flushA_busy", busy, 0);
        check_eq("flushA_in_ready", in_ready, 1);
        for (int c = 0; c < 5; c++) begin
            check_eq("flushA_no_valid", out_valid, 0);
            @(negedge clk);
        end
        check_eq("flushA_result", result, last_res);

        a = 16'hF00F;
        b = 16'h2233;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("flushD_valid", out_valid, 1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        out_ready = 1'b1;
        check_eq("flushD_drop", out_valid, 0);
        check_eq("flushD_busy", busy, 0);
        check_eq("flushD_result", result, ref_red(16'hF00F, 16'h2233));

        flush = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check_eq("flushI_no_accept", busy, 0);
        run_op(16'($urandom), 16'($urandom), 0);
`else
        last_res = result;
        check_eq("final_result_kept", result, last_res);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
